// File: rtl/btn_step_conditioner.sv
// -----------------------------------------------------------------------------
// btn_step_conditioner
//
// Turns the raw push-button (btnd) into clean one-cycle step events for the
// order-feed/strategy simulation. The button is synchronized into sys_clk,
// debounced by a four-state FSM, and each accepted press raises one step
// request. That request is handed off through a step_ready handshake that can
// hold at most one pending step. A wrapping counter records every step issued.
//
// Optional build macro:
//   BTN_AUTOREPEAT_EN - while the button stays held, raise further step
//                       requests REPEAT_DELAY cycles after the press is
//                       accepted, then every REPEAT_PERIOD cycles. When the
//                       macro is not defined, the repeat timer does not exist
//                       and each press gives exactly one step.
//
// Ports:
//   sys_clk     in   system clock; all logic runs on its rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   btn_raw     in   raw asynchronous button level
//   step_ready  in   downstream can accept a step in this cycle
//   step_pulse  out  one-cycle step event; only asserted while step_ready=1
//   btn_level   out  debounced button level (registered)
//   step_count  out  number of step_pulses issued; wraps to zero
//   overrun     out  sticky; a step request arrived while one was pending
// -----------------------------------------------------------------------------
module btn_step_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50,
    parameter int unsigned COUNT_W         = 16
`ifdef BTN_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 2000,
    parameter int unsigned REPEAT_PERIOD   = 500
`endif
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               btn_raw,
    input  logic               step_ready,
    output logic               step_pulse,
    output logic               btn_level,
    output logic [COUNT_W-1:0] step_count,
    output logic               overrun
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    // Terminal value of the debounce counter. The level must be stable for
    // DEBOUNCE_CYCLES samples in the wait state before it is accepted.
    localparam logic [15:0] DBNC_MAX = 16'(DEBOUNCE_CYCLES - 1);

    logic               s1_q, s1_d;
    logic               s2_q, s2_d;
    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               btn_level_q, btn_level_d;
    logic               req_q, req_d;
    logic               pending_q, pending_d;
    logic               overrun_q, overrun_d;
    logic [COUNT_W-1:0] step_count_q, step_count_d;
    logic               press_req;
    logic               repeat_req;

    // -------------------------------------------------------------------------
    // Two-flop synchronizer; only s2 feeds the FSM.
    // -------------------------------------------------------------------------
    always_comb begin
        s1_d = btn_raw;
        s2_d = s1_q;
    end

    // -------------------------------------------------------------------------
    // Debounce FSM. The counter restarts on every state entry, so each wait
    // state measures a fresh run of stable samples.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no
        // path through the block can leave it unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = '0;
        press_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s2_q) state_d = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!s2_q) begin
                    state_d = IDLE;           // glitch too short; no step
                end else if (cnt_q == DBNC_MAX) begin
                    state_d   = HELD;
                    press_req = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (!s2_q) state_d = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (s2_q) begin
                    state_d = HELD;           // bounce while held; no new step
                end else if (cnt_q == DBNC_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // The debounced level follows the FSM state it is entering, so it
        // changes on the same edge as the HELD / IDLE transition.
        btn_level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

`ifdef BTN_AUTOREPEAT_EN
    // -------------------------------------------------------------------------
    // Auto-repeat timer. It runs only while the FSM stays in HELD with the
    // button still down, and clears whenever HELD is left.
    // -------------------------------------------------------------------------
    localparam logic [15:0] RPT_DELAY_MAX  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_PERIOD_MAX = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_cnt_q, rpt_cnt_d;
    logic        rpt_armed_q, rpt_armed_d;   // first repeat already issued

    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        repeat_req  = 1'b0;
        if (state_q == HELD && s2_q) begin
            rpt_armed_d = rpt_armed_q;
            if (rpt_cnt_q == (rpt_armed_q ? RPT_PERIOD_MAX : RPT_DELAY_MAX)) begin
                repeat_req  = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = rpt_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign repeat_req = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Step handshake. A request is registered for one cycle. It fires directly
    // if the consumer is ready; otherwise it parks in the single pending slot.
    // A request that finds the slot already occupied is dropped and recorded
    // in the sticky overrun flag.
    // -------------------------------------------------------------------------
    always_comb begin
        req_d      = press_req | repeat_req;
        step_pulse = step_ready & (req_q | pending_q);
        pending_d  = pending_q;
        overrun_d  = overrun_q;
        if (pending_q) begin
            if (step_ready) pending_d = 1'b0;
            if (req_q)      overrun_d = 1'b1;
        end else if (req_q && !step_ready) begin
            pending_d = 1'b1;
        end
        step_count_d = step_count_q + COUNT_W'(step_pulse);
    end

    // NOTE: state is updated only with non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            btn_level_q  <= 1'b0;
            req_q        <= 1'b0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            step_count_q <= '0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            btn_level_q  <= btn_level_d;
            req_q        <= req_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            step_count_q <= step_count_d;
        end
    end

    assign btn_level  = btn_level_q;
    assign step_count = step_count_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_btn_step_conditioner.sv
// -----------------------------------------------------------------------------
// Directed bench for btn_step_conditioner. The DUT uses the default debounce
// length (50 cycles). step_count is narrowed to 8 bits so that the counter
// wrap can be reached within a short run. Inputs change 1 ns after a rising
// edge. Outputs are sampled on the falling edge. `cyc` counts rising edges.
// -----------------------------------------------------------------------------
module tb_btn_step_conditioner;

    localparam int DB = 50;
    localparam int CW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          btn_raw;
    logic          step_ready;
    logic          step_pulse;
    logic          btn_level;
    logic [CW-1:0] step_count;
    logic          overrun;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int pulse_cnt = 0;
    int exp_count = 0;
    int exp_pulses = 0;
    bit log_en    = 1'b0;
    int pulse_log[$];

    btn_step_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .COUNT_W         (CW)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .btn_raw    (btn_raw),
        .step_ready (step_ready),
        .step_pulse (step_pulse),
        .btn_level  (btn_level),
        .step_count (step_count),
        .overrun    (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (step_pulse) begin
            pulse_cnt++;
            if (log_en) pulse_log.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge_plus1();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) edge_plus1();
    endtask

    task automatic at_neg(input int target);
        do @(negedge sys_clk); while (cyc < target);
    endtask

    task automatic press(input int hi, input int lo);
        edge_plus1();
        btn_raw = 1'b1;
        cycles(hi);
        btn_raw = 1'b0;
        cycles(lo);
    endtask

    task automatic check_outputs_idle(input string tag);
        check({tag, "_pulse"},   32'(step_pulse), 0);
        check({tag, "_level"},   32'(btn_level),  0);
        check({tag, "_count"},   32'(step_count), 0);
        check({tag, "_overrun"}, 32'(overrun),    0);
    endtask

    int c0;
    int p0;

    initial begin
        btn_raw    = 1'b0;
        step_ready = 1'b1;
        sys_rst_n  = 1'b0;
        cycles(3);
        check_outputs_idle("reset");
        sys_rst_n = 1'b1;
        cycles(5);

        // Single press: pulse 53 cycles after the first sampling edge.
        c0 = cyc;
        btn_raw = 1'b1;
        at_neg(c0 + 52);
        check("t1_level_before", 32'(btn_level), 0);
        check("t1_no_early_pulse", 32'(pulse_cnt), 0);
        at_neg(c0 + 53);
        check("t1_pulse", 32'(step_pulse), 1);
        check("t1_level_held", 32'(btn_level), 1);
        at_neg(c0 + 54);
        check("t1_pulse_one_cycle", 32'(step_pulse), 0);
        check("t1_count", 32'(step_count), 1);
        exp_count = 1;
        exp_pulses = 1;
        while (cyc < c0 + 100) edge_plus1();
        btn_raw = 1'b0;
        at_neg(c0 + 152);
        check("t1_level_release_wait", 32'(btn_level), 1);
        at_neg(c0 + 153);
        check("t1_level_released", 32'(btn_level), 0);
        check("t1_total_pulses", 32'(pulse_cnt), 1);

        // Integration stimulus: 46 clean presses.
        p0 = pulse_cnt;
        repeat (46) press(100, 100);
        exp_count += 46;
        exp_pulses += 46;
        check("t2_pulses", 32'(pulse_cnt - p0), 46);
        check("t2_count", 32'(step_count), 32'(exp_count % 256));
        check("t2_overrun", 32'(overrun), 0);

        // A 30-cycle glitch is rejected.
        press(30, 100);
        check("t3_glitch_pulses", 32'(pulse_cnt), 32'(exp_pulses));
        check("t3_glitch_level", 32'(btn_level), 0);

        // Bounce at press only delays acceptance until the level is stable.
        edge_plus1();
        btn_raw = 1'b1; cycles(10);
        btn_raw = 1'b0; cycles(10);
        btn_raw = 1'b1; cycles(10);
        btn_raw = 1'b0; cycles(10);
        btn_raw = 1'b1;
        c0 = cyc;
        at_neg(c0 + 52);
        check("t3_bounce_no_early", 32'(pulse_cnt), 32'(exp_pulses));
        at_neg(c0 + 53);
        check("t3_bounce_pulse", 32'(step_pulse), 1);
        exp_pulses++;
        exp_count++;
        // A 20-cycle drop while held gives no second step.
        while (cyc < c0 + 100) edge_plus1();
        btn_raw = 1'b0;
        cycles(20);
        at_neg(cyc);
        check("t3_drop_level", 32'(btn_level), 1);
        edge_plus1();
        btn_raw = 1'b1;
        cycles(100);
        btn_raw = 1'b0;
        cycles(100);
        check("t3_drop_pulses", 32'(pulse_cnt), 32'(exp_pulses));
        check("t3_drop_count", 32'(step_count), 32'(exp_count % 256));
        check("t3_drop_released", 32'(btn_level), 0);

        // Step held back until ready, then fires in the first ready cycle.
        step_ready = 1'b0;
        press(100, 200);
        check("t4_held_back", 32'(pulse_cnt), 32'(exp_pulses));
        check("t4_count_hold", 32'(step_count), 32'(exp_count % 256));
        step_ready = 1'b1;
        at_neg(cyc);
        check("t4_pulse_first_ready", 32'(step_pulse), 1);
        at_neg(cyc + 1);
        exp_pulses++;
        exp_count++;
        check("t4_count_after", 32'(step_count), 32'(exp_count % 256));
        check("t4_no_overrun", 32'(overrun), 0);

        // A second press while a step is still pending sets overrun.
        edge_plus1();
        step_ready = 1'b0;
        press(100, 100);
        press(100, 100);
        check("t4_overrun", 32'(overrun), 1);
        check("t4_count_frozen", 32'(step_count), 32'(exp_count % 256));
        step_ready = 1'b1;
        cycles(20);
        exp_pulses++;
        exp_count++;
        check("t4_one_pulse_only", 32'(pulse_cnt), 32'(exp_pulses));
        check("t4_count_plus1", 32'(step_count), 32'(exp_count % 256));
        check("t4_overrun_sticky", 32'(overrun), 1);

        // Reset during PRESS_WAIT; a still-held button must debounce again.
        edge_plus1();
        btn_raw = 1'b1;
        cycles(20);
        sys_rst_n = 1'b0;
        #1;
        check_outputs_idle("t5_rst_press");
        exp_count = 0;
        cycles(3);
        sys_rst_n = 1'b1;
        c0 = cyc;
        at_neg(c0 + 52);
        check("t5_rearm_no_early", 32'(pulse_cnt), 32'(exp_pulses));
        check("t5_rearm_level", 32'(btn_level), 0);
        at_neg(c0 + 53);
        check("t5_rearm_pulse", 32'(step_pulse), 1);
        exp_pulses++;
        exp_count++;
        edge_plus1();
        btn_raw = 1'b0;
        cycles(100);

        // Reset while a step is pending: nothing stale after release.
        step_ready = 1'b0;
        press(100, 100);
        sys_rst_n = 1'b0;
        #1;
        check_outputs_idle("t5_rst_pending");
        exp_count = 0;
        step_ready = 1'b1;
        #1;
        check("t5_rst_ready_pulse", 32'(step_pulse), 0);
        cycles(2);
        sys_rst_n = 1'b1;
        cycles(100);
        check("t5_no_stale_pulse", 32'(pulse_cnt), 32'(exp_pulses));
        check("t5_count_zero", 32'(step_count), 0);

        // Long hold: one step, or auto-repeats when the feature is built in.
        pulse_log.delete();
        log_en = 1'b1;
        press(5000, 100);
        log_en = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        check("t6_hold_pulses", 32'(pulse_log.size()), 7);
        if (pulse_log.size() >= 3) begin
            check("t6_first_repeat", 32'(pulse_log[1] - pulse_log[0]), 2000);
            check("t6_period", 32'(pulse_log[2] - pulse_log[1]), 500);
        end
`else
        check("t6_hold_pulses", 32'(pulse_log.size()), 1);
`endif
        exp_pulses += pulse_log.size();
        exp_count  += pulse_log.size();
        check("t6_count", 32'(step_count), 32'(exp_count % 256));

        // Drive the counter to all-ones, then one more press wraps it to 0.
        while (exp_count % 256 != 255) begin
            press(60, 60);
            exp_count++;
            exp_pulses++;
        end
        check("t7_count_max", 32'(step_count), 255);
        press(60, 60);
        exp_pulses++;
        check("t7_count_wrap", 32'(step_count), 0);
        check("t7_total_pulses", 32'(pulse_cnt), 32'(exp_pulses));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
